// File: rtl/fifo_ctrl_if.sv
// Bundle of the FIFO controller's upstream write, downstream FWFT read, status and RAM port signals.
// slave = controller view, master = environment (producer, consumer and RAM) view.
interface fifo_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  ram_w_en;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [WIDTH-1:0]      ram_write_data;
  logic                  ram_r_en;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [WIDTH-1:0]      ram_read_data;

  modport slave (
    input  in_data, in_valid, out_ready, ram_read_data,
    output in_ready, out_data, out_valid, count, empty, full,
           ram_w_en, ram_write_addr, ram_write_data,
           ram_r_en, ram_read_addr
  );

  modport master (
    output in_data, in_valid, out_ready, ram_read_data,
    input  in_ready, out_data, out_valid, count, empty, full,
           ram_w_en, ram_write_addr, ram_write_data,
           ram_r_en, ram_read_addr
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with 1-cycle registered read; FWFT output, 2-cycle write-to-out latency.
// Backpressure: in_ready drops when the RAM holds DEPTH words; a stalled output freezes prefetch so out_data holds.
module fifo_ctrl #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic       clock,
  input  logic       reset,
  fifo_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH+1)'(1);

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                r_out_valid;

  logic [ADDR_WIDTH:0] w_mem_count;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_r_en;
  logic [WIDTH-1:0]    w_out_data;

  // Extra pointer bit distinguishes full (difference DEPTH) from empty (difference 0).
  assign w_mem_count = r_wr_ptr - r_rd_ptr;
  assign w_in_ready  = !reset && (w_mem_count != L_DEPTH);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_r_en      = !reset && (w_mem_count != '0) && (!r_out_valid || bus.out_ready);
  assign w_out_data  = bus.ram_read_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + L_ONE;
      end
      if (w_r_en) begin
        r_rd_ptr <= r_rd_ptr + L_ONE;
      end
      if (w_r_en) begin
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.ram_w_en       = w_accept;
  assign bus.ram_write_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_write_data = bus.in_data;
  assign bus.ram_r_en       = w_r_en;
  assign bus.ram_read_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
  assign bus.out_data       = w_out_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.count          = w_mem_count + {{ADDR_WIDTH{1'b0}}, r_out_valid};
  assign bus.empty          = (bus.count == '0);
  assign bus.full           = (w_mem_count == L_DEPTH);

  // Occupancy can never exceed the RAM size, and a held output word must not be overwritten.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    w_mem_count <= L_DEPTH);
  a_stall_holds: assert property (@(posedge clock) disable iff (reset)
    (r_out_valid && !bus.out_ready) |-> !w_r_en);
  a_no_collide: assert property (@(posedge clock) disable iff (reset)
    (w_accept && w_r_en) |-> (bus.ram_write_addr != bus.ram_read_addr));
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and scoreboarded checks of fifo_ctrl with a behavioural registered-read RAM.
module tb_fifo_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fifo_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(5)) bus ();

  fifo_ctrl #(.DEPTH(32), .WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple dual-port RAM: registered read, output holds while read enable is low.
  logic [7:0] mem [32];
  logic [7:0] rd_q;
  always @(posedge clock) begin
    if (bus.ram_w_en) mem[bus.ram_write_addr] <= bus.ram_write_data;
    if (bus.ram_r_en) rd_q <= mem[bus.ram_read_addr];
  end
  assign bus.ram_read_data = rd_q;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    bus.out_ready = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.ram_w_en !== 1'b0 || bus.ram_r_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_forced: in_ready=%b w_en=%b r_en=%b want 0 0 0",
               bus.in_ready, bus.ram_w_en, bus.ram_r_en);
    end
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b count=%0d empty=%b full=%b want 0 0 1 0",
               bus.out_valid, bus.count, bus.empty, bus.full);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.ram_w_en !== 1'b0 || bus.ram_r_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_enables: in_ready=%b w_en=%b r_en=%b want 1 0 0",
               bus.in_ready, bus.ram_w_en, bus.ram_r_en);
    end
  endtask

  task automatic test_single();
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bus.out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.ram_w_en !== 1'b1 || bus.ram_write_addr !== 5'd0 || bus.ram_write_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: w_en=%b addr=%0d data=%h want 1 0 a5",
               bus.ram_w_en, bus.ram_write_addr, bus.ram_write_data);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.ram_r_en !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_prefetch: r_en=%b out_valid=%b want 1 0", bus.ram_r_en, bus.out_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.count !== 6'd1) begin
      errors++;
      $display("FAIL single_out: out_valid=%b data=%h count=%0d want 1 a5 1",
               bus.out_valid, bus.out_data, bus.count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.ram_r_en !== 1'b0) begin
        errors++;
        $display("FAIL single_stall: cycle %0d out_valid=%b data=%h r_en=%b want 1 a5 0",
                 i, bus.out_valid, bus.out_data, bus.ram_r_en);
      end
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: empty=%b out_valid=%b want 1 0", bus.empty, bus.out_valid);
    end
  endtask

  task automatic test_fill();
    int got;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_accept: word %0d in_ready=%b want 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_data = 8'h77;
    @(negedge clock);
    checks++;
    if (bus.count !== 6'd33 || bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.ram_w_en !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d full=%b in_ready=%b w_en=%b want 33 1 0 0",
               bus.count, bus.full, bus.in_ready, bus.ram_w_en);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.count !== 6'd33) begin
      errors++;
      $display("FAIL fill_refused: count=%0d want 33", bus.count);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 33; c++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_data !== 8'(got)) begin
          errors++;
          $display("FAIL fill_drain: word %0d got %h want %h", got, bus.out_data, 8'(got));
        end
        got++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got != 33) begin
      errors++;
      $display("FAIL fill_drain_count: got %0d words want 33", got);
    end
    @(negedge clock);
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 6'd0) begin
      errors++;
      $display("FAIL fill_empty: empty=%b count=%0d want 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int first;
    tick();
    bus.out_ready = 1'b1;
    sent = 0;
    got = 0;
    first = -1;
    for (int c = 0; c < 202; c++) begin
      bus.in_valid = (sent < 200);
      bus.in_data = 8'(sent);
      @(negedge clock);
      checks++;
      if (bus.count > 6'd2) begin
        errors++;
        $display("FAIL stream_count: cycle %0d count=%0d want <=2", c, bus.count);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = c;
        checks++;
        if (bus.out_data !== 8'(got)) begin
          errors++;
          $display("FAIL stream_data: word %0d got %h want %h", got, bus.out_data, 8'(got));
        end
        got++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL stream_latency: first out cycle %0d want 2", first);
    end
    checks++;
    if (sent != 200 || got != 200) begin
      errors++;
      $display("FAIL stream_throughput: sent %0d got %0d want 200 200", sent, got);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic       hold;
    logic [7:0] hold_data;
    hold = 1'b0;
    hold_data = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data = 8'($urandom);
      @(negedge clock);
      checks++;
      if (int'(bus.count) != q.size()) begin
        errors++;
        $display("FAIL rand_count: cycle %0d count=%0d want %0d", c, bus.count, q.size());
      end
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== hold_data) begin
          errors++;
          $display("FAIL rand_stall: cycle %0d valid=%b data=%h want 1 %h",
                   c, bus.out_valid, bus.out_data, hold_data);
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: cycle %0d data=%h want no word", c, bus.out_data);
        end else begin
          exp = q.pop_front();
          if (bus.out_data !== exp) begin
            errors++;
            $display("FAIL rand_data: cycle %0d got %h want %h", c, bus.out_data, exp);
          end
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h80 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.count !== 6'd10) begin
      errors++;
      $display("FAIL mid_fill: count=%0d want 10", bus.count);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.count !== 6'd0 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: count=%0d out_valid=%b empty=%b want 0 0 1",
               bus.count, bus.out_valid, bus.empty);
    end
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.out_data !== 8'h3C) begin
          errors++;
          $display("FAIL mid_first: got %h want 3c", bus.out_data);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_timeout: out_valid never rose within 5 cycles");
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the team's simple dual-port block RAM and consumes its registered read port.
- Upstream side: ready/valid write interface. Downstream side: first-word-fall-through (FWFT) ready/valid read interface.
- Owns the write/read pointers, full/empty status, occupancy count and RAM read prefetch. The RAM instance sits outside this block.

Parameters:
- DEPTH, 32, number of RAM entries; must equal 2**ADDR_WIDTH (elaboration-time assertion).
- WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 5, RAM address width.

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  write data from upstream.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  controller can accept a word.
- out_data  output  WIDTH  head-of-FIFO word (driven from ram_read_data).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream consumes out_data.
- count  output  ADDR_WIDTH+1  words held (RAM plus output stage), range 0..DEPTH+1.
- empty  output  1  count == 0.
- full  output  1  RAM holds DEPTH words (equals !in_ready outside reset).
- ram_w_en  output  1  RAM write enable.
- ram_write_addr  output  ADDR_WIDTH  RAM write address.
- ram_write_data  output  WIDTH  RAM write data (equals in_data).
- ram_r_en  output  1  RAM read enable.
- ram_read_addr  output  ADDR_WIDTH  RAM read address.
- ram_read_data  input  WIDTH  RAM registered read data; 1-cycle latency; held while ram_r_en is low.

Behaviour:
- One clock. Reset is synchronous and active-high: sampled on the rising clock edge.
- On reset: wr_ptr = 0, rd_ptr = 0, out_valid = 0, count = 0, empty = 1, full = 0.
  - While reset is high, in_ready, ram_w_en and ram_r_en are forced to 0.
  - Reset mid-operation discards all contents. RAM data is not cleared.
  - out_data is undefined until the first out_valid.
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
  - mem_count = wr_ptr - rd_ptr, with modular arithmetic at ADDR_WIDTH+1 bits.
  - RAM addresses are ptr[ADDR_WIDTH-1:0].
- Write path (combinational enables):
  - in_ready = (mem_count != DEPTH).
  - accept = in_valid & in_ready.
  - ram_w_en = accept, ram_write_addr = wr_ptr low bits, ram_write_data = in_data.
  - wr_ptr increments on the clock edge when accept is high.
- Prefetch (combinational):
  - ram_r_en = (mem_count != 0) & (!out_valid | out_ready).
  - ram_read_addr = rd_ptr low bits.
  - rd_ptr increments on the edge when ram_r_en is high.
- Output stage:
  - out_valid_next = ram_r_en ? 1 : (out_valid & out_ready ? 0 : out_valid).
  - out_data = ram_read_data, combinational pass-through.
- Latency and throughput:
  - A write accepted in cycle t appears with out_valid = 1 in cycle t+2.
  - Sustained throughput is 1 word/cycle in and out when out_ready stays high.
- Backpressure: while out_valid & !out_ready, ram_r_en = 0, so out_data stays stable.
- count = mem_count + out_valid. empty = (count == 0). full = (mem_count == DEPTH).
- Total capacity is DEPTH+1 words.
- Simultaneous accept and ram_r_en are allowed in the same cycle.
  - Addresses never collide: equal addresses imply mem_count is 0 or DEPTH, which blocks read or write respectively.
  - The RAM's same-address bypass is therefore never exercised.
- Wrap: after 2*DEPTH writes, wr_ptr returns to 0. full/empty stay correct across wrap.
- out_ready while out_valid = 0 has no effect.
- in_valid while full: the word is not taken, and upstream must hold it.

Test Plan:
- Reset then idle → out_valid = 0, count = 0, empty = 1, full = 0, in_ready = 1, no RAM enables.
- Write 0xA5 at cycle 0 with out_ready = 0 → ram_r_en at cycle 1, out_valid = 1 and out_data = 0xA5 at cycle 2, count = 1; data holds for 5 cycles of stall.
- Write 33 words 0x00..0x20 with out_ready = 0 → after the 33rd, count = 33, full = 1, in_ready = 0; a 34th offer is refused; drain yields 0x00..0x20 in order, ending empty = 1.
- Continuous write and read of 200 incrementing words with out_ready = 1 → after a 2-cycle fill, one word per cycle out, in order; pointer wrap crossed 6 times; count stays ≤ 2.
- Random in_valid and out_ready (50%, 10k cycles) against a scoreboard → no loss, duplication or reorder; count always equals scoreboard depth; out_data stable while out_valid & !out_ready.
- Assert reset with count = 10 mid-stream → next cycle count = 0, out_valid = 0; a subsequent write of 0x3C emerges first.
